vram_rowbuf: RTL and testbench

Parametrised pixel video RAM. Writes are single pixels. Reads return one full row of pixels, packed, to the display scan-out path. Adds three things over the fixed-size VRAM: configurable geometry, a registered read with a valid strobe, and a hardware full-frame clear sequencer with a busy flag. It sits between the paint/draw engine (writer) and the LED-matrix row driver (reader).

---
 rtl/vram_rowbuf.sv | 98 +++++++++
 tb/tb_vram_rowbuf.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vram_rowbuf.sv
// Pixel VRAM with single-pixel writes, registered full-row reads and a one-row-per-cycle clear sweep.
// Optional macro VRAM_ROWBUF_WR_BYPASS_EN forwards a same-row write into a same-edge read.
module vram_rowbuf #(
   parameter int             PIX_W     = 8,
   parameter int             ROW_PIX   = 64,
   parameter int             ROWS      = 64,
   parameter logic [PIX_W-1:0] CLEAR_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr,
   input  logic [$clog2(ROWS)+$clog2(ROW_PIX)-1:0] wr_addr,
   input  logic [PIX_W-1:0]           in_data,
   input  logic                       rd,
   input  logic [$clog2(ROWS)-1:0]    rd_addr,
   output logic [ROW_PIX*PIX_W-1:0]   out_data,
   output logic                       out_valid,
   input  logic                       clear,
   output logic                       busy,
   output logic                       dbg_state
);
   localparam int COL_W    = $clog2(ROW_PIX);
   localparam int ROW_W    = $clog2(ROWS);
   localparam int ADDR_W   = ROW_W + COL_W;
   localparam int ROW_BITS = ROW_PIX * PIX_W;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   // Handshake: wr, rd and clear are single-cycle requests sampled at the rising edge,
   // accepted only while idle; out_valid is a one-cycle strobe marking a fresh out_data.
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t              state;
   logic [ROW_W-1:0]    sweep_row;
   logic [ROW_BITS-1:0] mem [ROWS];
   logic [ROW_W-1:0]    wr_row;
   logic [COL_W-1:0]    wr_col;
   logic                idle_go;
   logic                wr_en;
   logic [ROW_BITS-1:0] rd_row;

   assign wr_row    = wr_addr[ADDR_W-1:COL_W];
   assign wr_col    = wr_addr[COL_W-1:0];
   assign idle_go   = (state == IDLE) && !clear;
   assign wr_en     = idle_go && wr;
   assign dbg_state = state;

   always_comb begin
      rd_row = mem[rd_addr];
`ifdef VRAM_ROWBUF_WR_BYPASS_EN
      if (wr_en && (wr_row == rd_addr))
         rd_row[wr_col*PIX_W +: PIX_W] = in_data;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sweep_row <= '0;
         busy      <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (clear) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  sweep_row <= '0;
               end else if (rd) begin
                  out_data  <= rd_row;
                  out_valid <= 1'b1;
               end
            end
            CLEAR: begin
               if (sweep_row == LAST_ROW) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  sweep_row <= '0;
               end else begin
                  sweep_row <= sweep_row + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Contents survive reset; a reset edge only suppresses that edge's update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            mem[sweep_row] <= {ROW_PIX{CLEAR_VAL}};
         else if (wr_en)
            mem[wr_row][wr_col*PIX_W +: PIX_W] <= in_data;
      end
   end
endmodule

// File: tb/tb_vram_rowbuf.sv
// Directed bench for vram_rowbuf at default geometry: vector table plus clear/reset sequences.
module tb_vram_rowbuf;
   logic         clk = 1'b0;
   logic         rst, wr, rd, clear;
   logic [11:0]  wr_addr;
   logic [7:0]   in_data;
   logic [5:0]   rd_addr;
   logic [511:0] out_data;
   logic         out_valid, busy, dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [7:0] BYP_EXP =
`ifdef VRAM_ROWBUF_WR_BYPASS_EN
      8'h3C;
`else
      8'h00;
`endif

   vram_rowbuf dut (
      .clk(clk), .rst(rst), .wr(wr), .wr_addr(wr_addr), .in_data(in_data),
      .rd(rd), .rd_addr(rd_addr), .out_data(out_data), .out_valid(out_valid),
      .clear(clear), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [11:0] wa;
      logic [7:0]  d;
      logic        rd;
      logic [5:0]  ra;
      logic        ev;
      logic [5:0]  col;
      logic [7:0]  ep;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic w, input logic [11:0] wa, input logic [7:0] d,
                       input logic r, input logic [5:0] ra, input logic c);
      @(negedge clk);
      wr = w; wr_addr = wa; in_data = d; rd = r; rd_addr = ra; clear = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 12'd0, 8'd0, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin
         idle();
         n++;
      end
      if (busy) check(name, busy, 1'b0);
   endtask

   initial begin
      logic [511:0] exp_row;
      int  cnt;
      logic saw_valid;

      vt[0]  = '{1'b1, 12'd63,   8'hFF, 1'b0, 6'd0,  1'b0, 6'd0,  8'h00};
      vt[1]  = '{1'b0, 12'd0,    8'h00, 1'b1, 6'd0,  1'b1, 6'd63, 8'hFF};
      vt[2]  = '{1'b0, 12'd0,    8'h00, 1'b1, 6'd0,  1'b1, 6'd0,  8'h00};
      vt[3]  = '{1'b1, 12'd64,   8'hA5, 1'b0, 6'd0,  1'b0, 6'd0,  8'h00};
      vt[4]  = '{1'b0, 12'd0,    8'h00, 1'b1, 6'd1,  1'b1, 6'd0,  8'hA5};
      vt[5]  = '{1'b0, 12'd0,    8'h00, 1'b0, 6'd0,  1'b0, 6'd0,  8'hA5};
      vt[6]  = '{1'b1, 12'd130,  8'h3C, 1'b1, 6'd2,  1'b1, 6'd2,  BYP_EXP};
      vt[7]  = '{1'b0, 12'd0,    8'h00, 1'b1, 6'd2,  1'b1, 6'd2,  8'h3C};
      vt[8]  = '{1'b1, 12'd200,  8'h11, 1'b1, 6'd1,  1'b1, 6'd0,  8'hA5};
      vt[9]  = '{1'b0, 12'd0,    8'h00, 1'b1, 6'd3,  1'b1, 6'd8,  8'h11};
      vt[10] = '{1'b1, 12'd4095, 8'h77, 1'b0, 6'd0,  1'b0, 6'd8,  8'h11};
      vt[11] = '{1'b0, 12'd0,    8'h00, 1'b1, 6'd63, 1'b1, 6'd63, 8'h77};

      rst = 1'b1; wr = 1'b0; rd = 1'b0; clear = 1'b0; wr_addr = '0; in_data = '0; rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_data", out_data, '0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_state", dbg_state, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Full sweep; a write/read/clear issued mid-sweep must be ignored.
      step(1'b0, 12'd0, 8'd0, 1'b0, 6'd0, 1'b1);
      check("clear_busy_rise", busy, 1'b1);
      cnt = 0; saw_valid = 1'b0;
      while (busy && cnt < 200) begin
         cnt++;
         step(cnt == 20, 12'd0, 8'h55, cnt == 20, 6'd0, cnt == 20);
         if (out_valid) saw_valid = 1'b1;
      end
      check("clear_busy_cycles", cnt, 64);
      check("clear_no_valid", saw_valid, 1'b0);
      check("clear_state_idle", dbg_state, 1'b0);
      step(1'b0, 12'd0, 8'd0, 1'b1, 6'd0, 1'b0);
      check("read_valid", out_valid, 1'b1);
      check("row0_cleared", out_data, '0);
      idle();
      check("valid_one_cycle", out_valid, 1'b0);
      step(1'b0, 12'd0, 8'd0, 1'b1, 6'd31, 1'b0);
      check("row31_cleared", out_data, '0);
      step(1'b0, 12'd0, 8'd0, 1'b1, 6'd63, 1'b0);
      check("row63_cleared", out_data, '0);

      for (int i = 0; i < 12; i++) begin
         step(vt[i].wr, vt[i].wa, vt[i].d, vt[i].rd, vt[i].ra, 1'b0);
         check($sformatf("vec%0d_valid", i), out_valid, vt[i].ev);
         check($sformatf("vec%0d_pix", i), out_data[vt[i].col*8 +: 8], vt[i].ep);
      end

      exp_row = '0;
      exp_row[511:504] = 8'hFF;
      step(1'b0, 12'd0, 8'd0, 1'b1, 6'd0, 1'b0);
      check("row0_full", out_data, exp_row);

      // clear wins over same-edge wr and rd.
      step(1'b1, 12'd5, 8'h9A, 1'b1, 6'd1, 1'b1);
      check("clear_prio_valid", out_valid, 1'b0);
      check("clear_prio_busy", busy, 1'b1);
      check("clear_prio_hold", out_data, exp_row);
      wait_idle("clear_prio_timeout");
      step(1'b0, 12'd0, 8'd0, 1'b1, 6'd0, 1'b0);
      check("clear_prio_row0", out_data, '0);

      // Reset mid-sweep leaves later rows untouched.
      step(1'b1, 12'd2560, 8'h40, 1'b0, 6'd0, 1'b0);
      step(1'b1, 12'd1,    8'h01, 1'b0, 6'd0, 1'b0);
      step(1'b0, 12'd0, 8'd0, 1'b0, 6'd0, 1'b1);
      repeat (10) idle();
      check("mid_sweep_busy", busy, 1'b1);
      @(negedge clk);
      clear = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_state", dbg_state, 1'b0);
      check("rst_mid_out", out_data, '0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 12'd0, 8'd0, 1'b1, 6'd0, 1'b0);
      check("rst_mid_row0", out_data, '0);
      step(1'b0, 12'd0, 8'd0, 1'b1, 6'd40, 1'b0);
      check("rst_mid_row40", out_data[7:0], 8'h40);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
